regfile_scoreboard: RTL and testbench

//  Parametrised successor of the core integer register file: NREG x XLEN entries, NRD read ports and
//  NWR write-back ports, with an optional hardwired zero register. Adds a per-register pending
//  (scoreboard) bit, so the decode stage can tell when an operand is still in flight.

---
 rtl/regfile_scoreboard.sv | 81 ++++++++
 tb/tb_regfile_scoreboard.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREG x XLEN register file with per-register pending (scoreboard) bits.
// Define RF_WB_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter bit ZERO_REG = 1,
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0]   read_address,
  output logic [NRD*XLEN-1:0] read_data,
  output logic [NRD-1:0]      read_pending,
  input  logic [NWR-1:0]      write_en,
  input  logic [NWR*AW-1:0]   write_address,
  input  logic [NWR*XLEN-1:0] write_data,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_address,
  output logic              issue_stall,
  input  logic              clear_pending
);
  localparam int NSLOT = 1 << AW;
  localparam logic [NSLOT-1:0] VALID = {NSLOT{1'b1}} >> (NSLOT - NREG);
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic [NREG-1:0] w_wb_clr;
  logic [NREG-1:0] w_pend_eff;
  logic            w_issue_ok;
  // in range and not the hardwired zero register
  function automatic logic live(input logic [AW-1:0] a);
    return VALID[a] && !(ZERO_REG && a == '0);
  endfunction
  always_comb begin
    w_wb_clr = '0;
    for (int j = 0; j < NWR; j++)
      if (write_en[j] && live(write_address[j*AW +: AW])) w_wb_clr[write_address[j*AW +: AW]] = 1'b1;
  end
`ifdef RF_WB_BYPASS_EN
  assign w_pend_eff = r_pend & ~w_wb_clr;
`else
  assign w_pend_eff = r_pend;
`endif
  assign issue_stall = live(issue_address) && w_pend_eff[issue_address];
  assign w_issue_ok  = issue_en && !issue_stall && !clear_pending && live(issue_address);
  // issue overrides a same-edge write-back clear; flush overrides both
  always_comb begin
    w_pend_nxt = r_pend & ~w_wb_clr;
    if (w_issue_ok) w_pend_nxt[issue_address] = 1'b1;
    if (clear_pending) w_pend_nxt = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      for (int j = 0; j < NWR; j++)
        if (write_en[j] && live(write_address[j*AW +: AW]))
          r_regs[write_address[j*AW +: AW]] <= write_data[j*XLEN +: XLEN];
    end
  end
  always_comb begin
    read_data = '0;
    read_pending = '0;
    for (int i = 0; i < NRD; i++)
      if (live(read_address[i*AW +: AW])) begin
        read_data[i*XLEN +: XLEN] = r_regs[read_address[i*AW +: AW]];
        read_pending[i] = r_pend[read_address[i*AW +: AW]];
`ifdef RF_WB_BYPASS_EN
        for (int j = 0; j < NWR; j++)
          if (write_en[j] && write_address[j*AW +: AW] == read_address[i*AW +: AW]) begin
            read_data[i*XLEN +: XLEN] = write_data[j*XLEN +: XLEN];
            read_pending[i] = w_issue_ok && issue_address == read_address[i*AW +: AW];
          end
`endif
      end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed cases plus random traffic checked against a queue-fed
// scoreboard built from an array-based reference model of the register file.
module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREG = 32, NRD = 2, NWR = 2, AW = 5;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, ie, cp, st;
  logic [NRD*AW-1:0] ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0] rp;
  logic [NWR-1:0] we;
  logic [NWR*AW-1:0] wa;
  logic [NWR*XLEN-1:0] wd;
  logic [AW-1:0] ia;
  typedef struct packed {
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0] rp;
    logic st;
  } exp_t;
  exp_t q[$];
  logic [XLEN-1:0] m_reg [NREG];
  bit m_pend [NREG];
  int n_vec = 0, n_err = 0;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .read_address(ra), .read_data(rd), .read_pending(rp),
    .write_en(we), .write_address(wa), .write_data(wd), .issue_en(ie),
    .issue_address(ia), .issue_stall(st), .clear_pending(cp));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // value the highest write port delivers to register a this cycle
  function automatic logic [XLEN-1:0] written(input int a, output bit hit);
    hit = 1'b0;
    for (int j = NWR - 1; j >= 0; j--)
      if (we[j] && int'(wa[j*AW +: AW]) == a) begin
        hit = 1'b1;
        return wd[j*XLEN +: XLEN];
      end
    return '0;
  endfunction

  task automatic step();
    exp_t e;
    logic [XLEN-1:0] v;
    logic [XLEN-1:0] n_reg [NREG];
    bit n_pend [NREG];
    bit hit, stall, iss;
    int a;
    stall = m_pend[int'(ia)];
`ifdef RF_WB_BYPASS_EN
    v = written(int'(ia), hit);
    if (hit) stall = 1'b0;
`endif
    iss = ie && !stall && !cp && ia != 0;
    e.st = stall;
    for (int i = 0; i < NRD; i++) begin
      a = int'(ra[i*AW +: AW]);
      e.rd[i*XLEN +: XLEN] = (a == 0) ? '0 : m_reg[a];
      e.rp[i] = (a != 0) && m_pend[a];
`ifdef RF_WB_BYPASS_EN
      v = written(a, hit);
      if (hit && a != 0) begin
        e.rd[i*XLEN +: XLEN] = v;
        e.rp[i] = iss && int'(ia) == a;
      end
`endif
    end
    q.push_back(e);
    for (int r = 0; r < NREG; r++) begin
      v = written(r, hit);
      n_reg[r] = (reset || r == 0) ? '0 : hit ? v : m_reg[r];
      n_pend[r] = (reset || cp) ? 1'b0 : (iss && int'(ia) == r) ? 1'b1 : hit ? 1'b0 : m_pend[r];
    end
    @(posedge clk);
    m_reg = n_reg;
    m_pend = n_pend;
    #1;
  endtask

  task automatic idle();
    reset = 0; we = '0; wa = '0; wd = '0; ie = 0; ia = '0; cp = 0; ra = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("rd%0d", i), rd[i*XLEN +: XLEN], e.rd[i*XLEN +: XLEN]);
        chk($sformatf("rp%0d", i), 32'(rp[i]), 32'(e.rp[i]));
      end
      chk("stall", 32'(st), 32'(e.st));
    end
  end

  initial begin
    idle();
    reset = 1;
    for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_pend[r] = 0; end
    @(posedge clk); #1;
    idle();
    // reset clears data and pending
    we[0] = 1; wa[AW-1:0] = 5; wd[XLEN-1:0] = 32'hDEADBEEF; ie = 1; ia = 5'd6; step();
    idle(); ra[AW-1:0] = 5; reset = 1; step();
    idle(); ra = {5'd6, 5'd5}; #1;
    chk("t1_r5", rd[XLEN-1:0], 32'h0); chk("t1_pend", 32'(rp), 32'h0); step();
    // port priority
    idle(); we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11}; step();
    idle(); ra[AW-1:0] = 7; #1; chk("t2_r7", rd[XLEN-1:0], 32'h22); step();
    // scoreboard
    idle(); ie = 1; ia = 10; step();
    idle(); ie = 1; ia = 10; ra[AW-1:0] = 10; #1;
    chk("t3_pend", 32'(rp[0]), 32'h1); chk("t3_stall", 32'(st), 32'h1); step();
    idle(); we[0] = 1; wa[AW-1:0] = 10; wd[XLEN-1:0] = 32'h5; step();
    idle(); ra[AW-1:0] = 10; #1;
    chk("t3_clr", 32'(rp[0]), 32'h0); chk("t3_data", rd[XLEN-1:0], 32'h5); step();
    // same-edge issue and write, then flush
    idle(); ie = 1; ia = 3; we[0] = 1; wa[AW-1:0] = 3; wd[XLEN-1:0] = 32'h9; step();
    idle(); ra[AW-1:0] = 3; #1;
    chk("t4_data", rd[XLEN-1:0], 32'h9); chk("t4_pend", 32'(rp[0]), 32'h1); step();
    idle(); cp = 1; step();
    idle(); ra[AW-1:0] = 3; #1; chk("t4_flush", 32'(rp[0]), 32'h0); step();
    // zero register
    idle(); we[0] = 1; wa[AW-1:0] = 0; wd[XLEN-1:0] = 32'hFFFF; ie = 1; ia = 0; step();
    idle(); ie = 1; ia = 0; #1;
    chk("t5_data", rd[XLEN-1:0], 32'h0); chk("t5_pend", 32'(rp[0]), 32'h0);
    chk("t5_stall", 32'(st), 32'h0); step();
    // bypass visibility
    idle(); we[0] = 1; wa[AW-1:0] = 12; wd[XLEN-1:0] = 32'h33; step();
    idle(); ra[AW-1:0] = 12; we[0] = 1; wa[AW-1:0] = 12; wd[XLEN-1:0] = 32'hA5; #1;
`ifdef RF_WB_BYPASS_EN
    chk("t6_same", rd[XLEN-1:0], 32'hA5);
`else
    chk("t6_same", rd[XLEN-1:0], 32'h33);
`endif
    step();
    idle(); ra[AW-1:0] = 12; #1; chk("t6_next", rd[XLEN-1:0], 32'hA5); step();
    // random traffic on a narrow address range to force clashes
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      cp = ($urandom_range(0, 9) == 0);
      ie = 1'($urandom_range(0, 1));
      ia = 5'($urandom_range(0, 7));
      we = 2'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wa[j*AW +: AW] = 5'($urandom_range(0, 7));
        wd[j*XLEN +: XLEN] = $urandom;
      end
      for (int i = 0; i < NRD; i++)
        ra[i*AW +: AW] = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      step();
    end
    idle();
    repeat (3) @(posedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
